// File: rtl/csr_counter_pkg.sv
// csr_counter_pkg: CSR address map, modify opcodes and the read-modify helper
// shared by the performance-counter CSR slave.
package csr_counter_pkg;

    // User-level read-only views
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    // Machine-level writable views
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    typedef enum logic [2:0] {
        MOD_NONE  = 3'b000,
        MOD_WRITE = 3'b001,
        MOD_SET   = 3'b010,
        MOD_CLEAR = 3'b011
    } modify_e;

    // True for the three opcodes that change register contents.
    function automatic logic is_modify(input logic [2:0] op);
        return (op == MOD_WRITE) || (op == MOD_SET) || (op == MOD_CLEAR);
    endfunction

    // New half-register value for a given opcode; unknown opcodes keep the old value.
    function automatic logic [31:0] apply_modify(input logic [2:0]  op,
                                                 input logic [31:0] old,
                                                 input logic [31:0] operand);
        logic [31:0] result;
        result = old;
        case (op)
            MOD_WRITE: result = operand;
            MOD_SET:   result = old | operand;
            MOD_CLEAR: result = old & ~operand;
            default:   result = old;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_counter_counter64.sv
// counter64: 64-bit wrapping counter with increment enable and a 32-bit
// half-load. A load wins over the increment and holds the other half.
module counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        load,
    input  logic        sel_hi,
    input  logic [31:0] load_val,
    output logic [63:0] count
);

    // Count register: reset, half-load, or full-width increment with carry across halves
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 64'd0;
        end else if (load) begin
            if (sel_hi) begin
                count[63:32] <= load_val;
            end else begin
                count[31:0] <= load_val;
            end
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_counter.sv
// csr_counter: cycle / time / instret performance-counter CSR slave.
// Read data and valid are registered and zero when the address misses, so
// the outputs can be OR-ed with other CSR slaves.
// Build option: define CSR_COUNTER_WRITE_EN to make mcycle/minstret writable;
// without it every modify is ignored and both counters free-run.
module csr_counter
    import csr_counter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        retired
);

    logic        hit;
    logic        sel_instret;
    logic        sel_hi;
    logic        writable;
    logic [63:0] cycle_q;
    logic [63:0] instret_q;
    logic [31:0] old_half;
    logic [31:0] new_half;
    logic        mod_hit;

    // The read strobe carries no meaning here; the address alone selects.
    logic unused_read;
    assign unused_read = read;

    // Address decode: which counter, which half, and whether it is a machine (writable) view
    always_comb begin
        hit         = 1'b0;
        sel_instret = 1'b0;
        sel_hi      = 1'b0;
        writable    = 1'b0;
        case (addr)
            ADDR_CYCLE, ADDR_TIME: begin
                hit = 1'b1;
            end
            ADDR_CYCLEH, ADDR_TIMEH: begin
                hit    = 1'b1;
                sel_hi = 1'b1;
            end
            ADDR_INSTRET: begin
                hit         = 1'b1;
                sel_instret = 1'b1;
            end
            ADDR_INSTRETH: begin
                hit         = 1'b1;
                sel_instret = 1'b1;
                sel_hi      = 1'b1;
            end
            ADDR_MCYCLE: begin
                hit      = 1'b1;
                writable = 1'b1;
            end
            ADDR_MCYCLEH: begin
                hit      = 1'b1;
                sel_hi   = 1'b1;
                writable = 1'b1;
            end
            ADDR_MINSTRET: begin
                hit         = 1'b1;
                sel_instret = 1'b1;
                writable    = 1'b1;
            end
            ADDR_MINSTRETH: begin
                hit         = 1'b1;
                sel_instret = 1'b1;
                sel_hi      = 1'b1;
                writable    = 1'b1;
            end
            default: ;
        endcase
    end

    assign old_half = sel_instret ? (sel_hi ? instret_q[63:32] : instret_q[31:0])
                                  : (sel_hi ? cycle_q[63:32]   : cycle_q[31:0]);
    assign new_half = apply_modify(modify, old_half, wdata);

`ifdef CSR_COUNTER_WRITE_EN
    assign mod_hit = hit & writable & is_modify(modify);
`else
    logic unused_writable;
    assign unused_writable = writable;
    assign mod_hit = 1'b0;
`endif

    counter64 u_cycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .load     (mod_hit & ~sel_instret),
        .sel_hi   (sel_hi),
        .load_val (new_half),
        .count    (cycle_q)
    );

    counter64 u_instret (
        .clk      (clk),
        .rst      (rst),
        .inc      (retired),
        .load     (mod_hit & sel_instret),
        .sel_hi   (sel_hi),
        .load_val (new_half),
        .count    (instret_q)
    );

    // Registered read port: pre-update value of the selected half, zero on a miss
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            rdata <= 32'd0;
        end else begin
            valid <= hit;
            rdata <= hit ? old_half : 32'd0;
        end
    end

endmodule

// File: tb/tb_csr_counter.sv
// tb_csr_counter: directed, table-driven bench for csr_counter. Expected
// values for modify sequences depend on whether CSR_COUNTER_WRITE_EN is defined.
module tb_csr_counter;

    logic        clk;
    logic        rst;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        retired;

    int n_checks;
    int n_fail;

`ifdef CSR_COUNTER_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    localparam logic [2:0] M_NONE  = 3'b000;
    localparam logic [2:0] M_WRITE = 3'b001;
    localparam logic [2:0] M_SET   = 3'b010;
    localparam logic [2:0] M_CLEAR = 3'b011;
    localparam logic [11:0] MISS   = 12'h7C1;

    typedef struct {
        logic [11:0] addr;
        logic [2:0]  modify;
        logic [31:0] wdata;
        logic        retired;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[23];

    csr_counter dut (
        .clk     (clk),
        .rst     (rst),
        .read    (read),
        .modify  (modify),
        .wdata   (wdata),
        .addr    (addr),
        .rdata   (rdata),
        .valid   (valid),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present one cycle of inputs, clock once, then check the registered outputs.
    task automatic step(input string name, input logic [11:0] a, input logic [2:0] m,
                        input logic [31:0] wd, input logic ret,
                        input logic ev, input logic [31:0] er);
        addr    = a;
        modify  = m;
        wdata   = wd;
        retired = ret;
        read    = 1'b1;
        @(posedge clk);
        #1;
        check({name, ".valid"}, {31'd0, valid}, {31'd0, ev});
        check({name, ".rdata"}, rdata, er);
    endtask

    // Hold reset for two edges with a hit address presented; outputs must stay zero.
    task automatic do_reset(input string name);
        rst     = 1'b1;
        addr    = 12'hC00;
        modify  = M_NONE;
        wdata   = 32'd0;
        retired = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({name, ".valid"}, {31'd0, valid}, 32'd0);
        check({name, ".rdata"}, rdata, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        read     = 1'b0;
        modify   = M_NONE;
        wdata    = 32'd0;
        addr     = MISS;
        retired  = 1'b0;

        // Table rows are steps 11..33 after reset release; cycle read = step-1.
        tbl[0]  = '{12'hC00, M_NONE, 32'd0, 1'b0, 1'b1, 32'd10};
        tbl[1]  = '{MISS,    M_NONE, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{12'hC80, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[3]  = '{12'hC01, M_NONE, 32'd0, 1'b0, 1'b1, 32'd13};
        tbl[4]  = '{12'hC81, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[5]  = '{12'hB00, M_NONE, 32'd0, 1'b0, 1'b1, 32'd15};
        tbl[6]  = '{12'hB80, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[7]  = '{MISS,    M_NONE, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[8]  = '{MISS,    M_NONE, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[9]  = '{MISS,    M_NONE, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[10] = '{MISS,    M_NONE, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[11] = '{MISS,    M_NONE, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[12] = '{MISS,    M_NONE, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[13] = '{MISS,    M_NONE, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[14] = '{MISS,    M_NONE, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[15] = '{12'hC02, M_NONE, 32'd0, 1'b0, 1'b1, 32'd5};
        tbl[16] = '{12'hC82, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[17] = '{12'hB02, M_NONE, 32'd0, 1'b0, 1'b1, 32'd5};
        tbl[18] = '{12'hB82, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[19] = '{12'hC02, M_NONE, 32'd0, 1'b1, 1'b1, 32'd5};
        tbl[20] = '{12'hC02, M_NONE, 32'd0, 1'b0, 1'b1, 32'd6};
        tbl[21] = '{12'hC03, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[22] = '{12'hB01, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0};

        do_reset("reset0");

        for (int i = 0; i < 10; i++) begin
            step($sformatf("idle[%0d]", i), MISS, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0);
        end
        for (int i = 0; i < 23; i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].modify, tbl[i].wdata,
                 tbl[i].retired, tbl[i].exp_valid, tbl[i].exp_rdata);
        end

        // Carry from low half into high half after loading 0x0_FFFFFFFE
        do_reset("resetA");
        step("carry.wlo", 12'hB00, M_WRITE, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd0);
        step("carry.whi", 12'hB80, M_WRITE, 32'd0, 1'b0, 1'b1, 32'd0);
        step("carry.i1",  MISS, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0);
        step("carry.i2",  MISS, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0);
        step("carry.hi",  12'hC80, M_NONE, 32'd0, 1'b0, 1'b1, WEN ? 32'd1 : 32'd0);
        step("carry.lo",  12'hC00, M_NONE, 32'd0, 1'b0, 1'b1, WEN ? 32'd1 : 32'd5);

        // Full 64-bit wrap from all-ones to zero
        do_reset("resetW");
        step("wrap.wlo", 12'hB00, M_WRITE, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0);
        step("wrap.whi", 12'hB80, M_WRITE, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0);
        step("wrap.hi1", 12'hC80, M_NONE, 32'd0, 1'b0, 1'b1, WEN ? 32'hFFFF_FFFF : 32'd0);
        step("wrap.hi2", 12'hC80, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0);
        step("wrap.lo",  12'hC00, M_NONE, 32'd0, 1'b0, 1'b1, WEN ? 32'd1 : 32'd4);

        // Write / set / clear on minstret, modify suppresses a coincident retire
        do_reset("resetB");
        step("mod.write", 12'hB02, M_WRITE, 32'h0000_00F0, 1'b0, 1'b1, 32'd0);
        step("mod.set",   12'hB02, M_SET,   32'h0000_000F, 1'b0, 1'b1, WEN ? 32'hF0 : 32'd0);
        step("mod.clear", 12'hB02, M_CLEAR, 32'h0000_0030, 1'b0, 1'b1, WEN ? 32'hFF : 32'd0);
        step("mod.read",  12'hB02, M_NONE,  32'd0, 1'b0, 1'b1, WEN ? 32'hCF : 32'd0);
        step("mod.wret",  12'hB02, M_WRITE, 32'h0000_0100, 1'b1, 1'b1, WEN ? 32'hCF : 32'd0);
        step("mod.ulo",   12'hC02, M_NONE,  32'd0, 1'b0, 1'b1, WEN ? 32'h100 : 32'd1);
        step("mod.uhi",   12'hC82, M_NONE,  32'd0, 1'b0, 1'b1, 32'd0);
        step("mod.sethi", 12'hB82, M_SET,   32'd3, 1'b0, 1'b1, 32'd0);
        step("mod.hi",    12'hC82, M_NONE,  32'd0, 1'b0, 1'b1, WEN ? 32'd3 : 32'd0);
        step("mod.lohold",12'hC02, M_NONE,  32'd0, 1'b0, 1'b1, WEN ? 32'h100 : 32'd1);
        step("mod.cyc",   12'hC00, M_NONE,  32'd0, 1'b0, 1'b1, 32'd10);

        // Modifies to read-only views and unknown opcodes are ignored
        do_reset("resetC");
        step("ro.i1",    MISS, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0);
        step("ro.i2",    MISS, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0);
        step("ro.i3",    MISS, M_NONE, 32'd0, 1'b0, 1'b0, 32'd0);
        step("ro.write", 12'hC00, M_WRITE, 32'd0, 1'b0, 1'b1, 32'd3);
        step("ro.after", 12'hC00, M_NONE,  32'd0, 1'b0, 1'b1, 32'd4);
        step("ro.time",  12'hC01, M_NONE,  32'd0, 1'b0, 1'b1, 32'd5);
        step("ro.clear", 12'hC00, M_CLEAR, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd6);
        step("ro.timeh", 12'hC81, M_WRITE, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0);
        step("ro.badop", 12'hB00, 3'b100,  32'd0, 1'b0, 1'b1, 32'd8);
        step("ro.chk",   12'hC00, M_NONE,  32'd0, 1'b0, 1'b1, 32'd9);

        // Reset wins over a coincident write to mcycle
        rst     = 1'b1;
        addr    = 12'hB00;
        modify  = M_WRITE;
        wdata   = 32'h0000_1234;
        retired = 1'b1;
        @(posedge clk);
        #1;
        check("rstwr.valid", {31'd0, valid}, 32'd0);
        check("rstwr.rdata", rdata, 32'd0);
        rst = 1'b0;
        step("rstwr.lo",  12'hC00, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0);
        step("rstwr.m",   12'hB00, M_NONE, 32'd0, 1'b0, 1'b1, 32'd1);
        step("rstwr.ins", 12'hC02, M_NONE, 32'd0, 1'b0, 1'b1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
